// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and entry type for the ALU result path
//
// Purpose : common definitions used by the ALU result buffer and its FIFO.
// Ports   : none (package).

package alu_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_EQ  = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_GT  = 3'b111;

   // Bit positions inside the 5-bit flag vector {carry, zero, eq, lt, gt}.
   localparam int FLAG_GT    = 0;
   localparam int FLAG_LT    = 1;
   localparam int FLAG_EQ    = 2;
   localparam int FLAG_ZERO  = 3;
   localparam int FLAG_CARRY = 4;

   localparam int ENTRY_W = 11;

   typedef struct packed {
      logic [2:0] sel;
      logic [2:0] result;
      logic [4:0] flags;
   } alu_entry_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// rtl/alu_result_buffer_if.sv - producer/consumer/status bundle of the ALU result buffer
//
// Purpose : groups the ALU capture side, the consumer handshake and the statistics.
// Signals : in_valid/in_sel/in_result/in_flags (ALU strobe), out_valid/out_ready/
//           out_sel/out_result/out_flags (FWFT head), level, sticky_carry,
//           sticky_zero, drop_count, clear_stats.
// Modports: master = environment driving the buffer, slave = the buffer itself.

interface alu_result_buffer_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
);
   import alu_pkg::*;

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic [2:0]       in_sel;
   logic [2:0]       in_result;
   logic [4:0]       in_flags;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_sel;
   logic [2:0]       out_result;
   logic [4:0]       out_flags;
   logic [LVL_W-1:0] level;
   logic             sticky_carry;
   logic             sticky_zero;
   logic [CNT_W-1:0] drop_count;
   logic             clear_stats;

   modport master (
      output in_valid, in_sel, in_result, in_flags, out_ready, clear_stats,
      input  out_valid, out_sel, out_result, out_flags, level,
             sticky_carry, sticky_zero, drop_count
   );

   modport slave (
      input  in_valid, in_sel, in_result, in_flags, out_ready, clear_stats,
      output out_valid, out_sel, out_result, out_flags, level,
             sticky_carry, sticky_zero, drop_count
   );

endinterface

// File: rtl/alu_fwft_fifo.sv
// rtl/alu_fwft_fifo.sv - generic DEPTH x WIDTH first-word-fall-through FIFO
//
// Purpose : register-array FIFO whose head is visible combinationally.
// Ports   : clk, rst_n (async, active-low), i_push/i_wdata (write),
//           i_pop (consume head), o_rdata (head, zero while empty),
//           o_level (occupancy 0..DEPTH).

module alu_fwft_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_wdata,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   logic w_empty;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_level == '0);
   assign w_do_pop  = i_pop & ~w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_do_push = i_push & ((r_level != FULL_LVL) | w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Data array needs no reset: emptiness is tracked by r_level alone.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - buffers ALU results with sticky status and drop counting
//
// Purpose : qualifies ALU strobes into a FWFT FIFO, keeps sticky carry/zero
//           and a saturating count of strobes lost to a full buffer.
// Ports   : clk, rst_n (async, active-low), bus (alu_result_buffer_if.slave).

module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_result_buffer_if.slave   bus
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   alu_entry_t       w_in_entry;
   alu_entry_t       w_head;
   logic [LVL_W-1:0] w_level;
   logic             w_out_valid;
   logic             w_req;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_set_carry;
   logic             w_set_zero;

   logic             r_sticky_carry;
   logic             r_sticky_zero;
   logic [CNT_W-1:0] r_drop_count;

   assign w_in_entry  = {bus.in_sel, bus.in_result, bus.in_flags};
   assign w_out_valid = (w_level != '0);
   assign w_full      = (w_level == FULL_LVL);
   assign w_pop       = w_out_valid & bus.out_ready;

   // NOP strobes are ignored outright; they never count as drops.
   assign w_req  = bus.in_valid & (bus.in_sel != OP_NOP);
   assign w_push = w_req & (~w_full | w_pop);
   assign w_drop = w_req & w_full & ~w_pop;

   // Carry only means something for arithmetic opcodes.
   assign w_set_carry = w_push & w_in_entry.flags[FLAG_CARRY] &
                        ((w_in_entry.sel == OP_ADD) | (w_in_entry.sel == OP_SUB));
   assign w_set_zero  = w_push & w_in_entry.flags[FLAG_ZERO];

   alu_fwft_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_in_entry),
      .o_rdata (w_head),
      .o_level (w_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_carry <= 1'b0;
         r_sticky_zero  <= 1'b0;
         r_drop_count   <= '0;
      end else begin
         // A set in the same cycle as clear_stats wins.
         r_sticky_carry <= w_set_carry | (r_sticky_carry & ~bus.clear_stats);
         r_sticky_zero  <= w_set_zero  | (r_sticky_zero  & ~bus.clear_stats);
         if (bus.clear_stats)
            r_drop_count <= w_drop ? CNT_W'(1) : '0;
         else if (w_drop && (r_drop_count != '1))
            r_drop_count <= r_drop_count + CNT_W'(1);
      end
   end

   assign bus.out_valid    = w_out_valid;
   assign bus.out_sel      = w_head.sel;
   assign bus.out_result   = w_head.result;
   assign bus.out_flags    = w_head.flags;
   assign bus.level        = w_level;
   assign bus.sticky_carry = r_sticky_carry;
   assign bus.sticky_zero  = r_sticky_zero;
   assign bus.drop_count   = r_drop_count;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer

module tb_alu_result_buffer;
   import alu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a plain queue plus statistic variables.
   logic [10:0] m_q [$];
   bit          m_sc;
   bit          m_sz;
   int          m_drops;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_sc    = 0;
      m_sz    = 0;
      m_drops = 0;
   endtask

   task automatic check_model();
      logic [10:0] h;
      h = (m_q.size() != 0) ? m_q[0] : 11'd0;
      chk("out_valid",    32'(bus.out_valid),    32'(m_q.size() != 0));
      chk("level",        32'(bus.level),        32'(m_q.size()));
      chk("out_sel",      32'(bus.out_sel),      32'(h[10:8]));
      chk("out_result",   32'(bus.out_result),   32'(h[7:5]));
      chk("out_flags",    32'(bus.out_flags),    32'(h[4:0]));
      chk("sticky_carry", 32'(bus.sticky_carry), 32'(m_sc));
      chk("sticky_zero",  32'(bus.sticky_zero),  32'(m_sz));
      chk("drop_count",   32'(bus.drop_count),   32'(m_drops));
   endtask

   task automatic model_edge(input bit v, input logic [2:0] s, input logic [2:0] r,
                             input logic [4:0] f, input bit rdy, input bit clr);
      bit pushed;
      bit dropped;
      pushed  = 0;
      dropped = 0;
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (v && s != 3'b000) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back({s, r, f});
            pushed = 1;
         end else begin
            dropped = 1;
         end
      end
      if (clr) begin
         m_sc    = 0;
         m_sz    = 0;
         m_drops = 0;
      end
      if (pushed && f[4] && (s == 3'b001 || s == 3'b010)) m_sc = 1;
      if (pushed && f[3]) m_sz = 1;
      if (dropped && m_drops < CNT_MAX) m_drops++;
   endtask

   // One clock: apply inputs, check at the falling edge, advance model at the rising edge.
   task automatic cycle(input bit v, input logic [2:0] s, input logic [2:0] r,
                        input logic [4:0] f, input bit rdy, input bit clr);
      bus.in_valid    = v;
      bus.in_sel      = s;
      bus.in_result   = r;
      bus.in_flags    = f;
      bus.out_ready   = rdy;
      bus.clear_stats = clr;
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_edge(v, s, r, f, rdy, clr);
      #1;
   endtask

   task automatic idle(input bit rdy);
      cycle(0, 3'b000, 3'b000, 5'b00000, rdy, 0);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_sel      = 3'b000;
      bus.in_result   = 3'b000;
      bus.in_flags    = 5'b00000;
      bus.out_ready   = 1'b0;
      bus.clear_stats = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single push then pop.
      cycle(1, OP_ADD, 3'b011, 5'b00000, 0, 0);
      chk("tp1_valid",  32'(bus.out_valid),  32'd1);
      chk("tp1_result", 32'(bus.out_result), 32'd3);
      chk("tp1_level",  32'(bus.level),      32'd1);
      idle(1);
      chk("tp1_drained", 32'(bus.level), 32'd0);
      chk("tp1_nvalid",  32'(bus.out_valid), 32'd0);

      // Fill and overflow.
      for (int i = 1; i <= 5; i++) cycle(1, OP_OR, 3'(i), 5'b00000, 0, 0);
      chk("tp2_level", 32'(bus.level),      32'd4);
      chk("tp2_drops", 32'(bus.drop_count), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("tp2_order", 32'(bus.out_result), 32'(i));
         idle(1);
      end

      // Full with simultaneous push and pop.
      for (int i = 1; i <= 4; i++) cycle(1, OP_OR, 3'(i), 5'b00000, 0, 0);
      cycle(1, OP_OR, 3'd6, 5'b00000, 1, 0);
      chk("tp3_level", 32'(bus.level),      32'd4);
      chk("tp3_drops", 32'(bus.drop_count), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("tp3_order", 32'(bus.out_result), (i == 3) ? 32'd6 : 32'(i + 2));
         idle(1);
      end

      // Sticky flags.
      cycle(0, OP_NOP, 3'd0, 5'b00000, 1, 1);
      cycle(1, OP_ADD, 3'b000, 5'b11000, 1, 0);
      chk("tp4_carry_add", 32'(bus.sticky_carry), 32'd1);
      chk("tp4_zero_add",  32'(bus.sticky_zero),  32'd1);
      cycle(0, OP_NOP, 3'd0, 5'b00000, 1, 1);
      cycle(1, OP_AND, 3'b001, 5'b10000, 1, 0);
      chk("tp4_carry_and", 32'(bus.sticky_carry), 32'd0);
      cycle(1, OP_SUB, 3'b111, 5'b10010, 1, 1);
      chk("tp4_carry_clr", 32'(bus.sticky_carry), 32'd1);
      idle(1);

      // NOP while full and saturation.
      cycle(0, OP_NOP, 3'd0, 5'b00000, 1, 1);
      for (int i = 0; i < 4; i++) cycle(1, OP_EQ, 3'(i), 5'b00100, 0, 0);
      cycle(1, OP_NOP, 3'd5, 5'b00000, 0, 0);
      chk("tp5_nop_drop", 32'(bus.drop_count), 32'd0);
      for (int i = 0; i < 300; i++) cycle(1, OP_GT, 3'($urandom), 5'b00001, 0, 0);
      chk("tp5_saturate", 32'(bus.drop_count), 32'd255);
      cycle(1, OP_LT, 3'd2, 5'b00010, 0, 1);
      chk("tp5_drop_clr", 32'(bus.drop_count), 32'd1);

      // Asynchronous reset mid-stream with three entries.
      idle(1);
      chk("tp6_pre_level", 32'(bus.level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("tp6_rst_valid", 32'(bus.out_valid),  32'd0);
      chk("tp6_rst_level", 32'(bus.level),      32'd0);
      chk("tp6_rst_drops", 32'(bus.drop_count), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1, OP_SUB, 3'b101, 5'b00000, 0, 0);
      chk("tp6_post_level",  32'(bus.level),      32'd1);
      chk("tp6_post_result", 32'(bus.out_result), 32'd5);
      idle(1);

      // Randomized traffic against the model.
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom % 4) != 0, 3'($urandom), 3'($urandom), 5'($urandom),
               ($urandom % 5) < 2, ($urandom % 25) == 0);
      end
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 3-bit combinational ALU.
- Captures each issued ALU result and its status flags into a small first-word-fall-through (FWFT) FIFO.
- Presents buffered entries to the consumer over a valid/ready handshake.
- Keeps sticky carry/zero status and a saturating drop counter, because the ALU source cannot be stalled.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CNT_W, 8, width of drop_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  one-cycle strobe: ALU outputs are valid this cycle.
- in_sel  input  3  opcode applied to the ALU (001 ADD, 010 SUB, 011 AND, 100 OR, 101 EQ, 110 LT, 111 GT).
- in_result  input  3  ALU result.
- in_flags  input  5  {carry_out, zero, equal, less_than, greater_than}.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_sel  output  3  head entry opcode.
- out_result  output  3  head entry result.
- out_flags  output  5  head entry flags, same order as in_flags.
- level  output  clog2(DEPTH)+1  current occupancy.
- sticky_carry  output  1  carry/borrow seen on an accepted ADD or SUB since the last clear.
- sticky_zero  output  1  zero flag seen on an accepted entry since the last clear.
- drop_count  output  CNT_W  number of strobes lost because the FIFO was full; saturating.
- clear_stats  input  1  synchronous clear of sticky_carry, sticky_zero and drop_count.

Behaviour:
- Reset (rst_n low, asynchronous): read/write pointers = 0, level = 0, out_valid = 0, sticky_carry = 0, sticky_zero = 0, drop_count = 0. out_sel, out_result and out_flags = 0 while empty.
- Storage:
  - Entry = {sel, result, flags}, 11 bits, held in a register array.
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - level distinguishes full from empty.
- pop = out_valid & out_ready.
- push = in_valid & (in_sel != 3'b000) & (level < DEPTH | pop).
  - A strobe with in_sel = 000 is discarded silently; it is not a drop.
- drop = in_valid & (in_sel != 3'b000) & (level == DEPTH) & ~pop.
  - On drop, drop_count increments and holds at all-ones.
- FWFT:
  - out_valid = (level != 0).
  - out_* show the head entry combinationally from the array.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop:
  - Both occur; level is unchanged.
  - When full, the pop frees a slot so the push is accepted, not dropped.
- Handshake rule: out_* hold stable while out_valid = 1 and out_ready = 0.
- Sticky flags (set only by accepted pushes):
  - sticky_carry sets when the pushed carry = 1 and in_sel is 001 or 010.
  - sticky_zero sets when the pushed zero = 1.
  - clear_stats clears sticky_carry, sticky_zero and drop_count on the next edge.
  - If a set and clear_stats occur in the same cycle, the set wins for the sticky bits.
  - A drop and clear_stats in the same cycle leave drop_count = 1.
- Reset mid-operation: all buffered entries are discarded immediately; no partial entry survives.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_NOP 000, OP_ADD 001, OP_SUB 010, OP_AND 011, OP_OR 100, OP_EQ 101, OP_LT 110, OP_GT 111;
  - flag bit index constants;
  - the 11-bit entry typedef.
- One natural sub-module, alu_fwft_fifo: generic DEPTH x width FWFT FIFO providing push, pop, level and head.
- The top level adds the push/drop qualification, the sticky flags and the drop counter.

Test Plan:
- Reset then single push: in_valid with sel 001, result 3'b011, flags 5'b00000 -> next cycle out_valid = 1, out_result = 011, level = 1. out_ready = 1 -> level = 0 and out_valid = 0 next cycle.
- Fill and overflow: 5 strobes with out_ready = 0 and results 1, 2, 3, 4, 5 -> level = 4 and drop_count = 1. Draining yields 1, 2, 3, 4 in order.
- Full with simultaneous push and pop: level = 4, out_ready = 1, push result 6 -> level stays 4, drop_count unchanged, and 6 emerges fourth.
- Sticky flags:
  - ADD 7 + 1 (result 000, carry 1) -> sticky_carry = 1.
  - AND with carry 1 from a fault injection -> sticky_carry does not set.
  - clear_stats together with a SUB borrow -> sticky_carry stays 1.
- NOP and saturation: sel 000 strobe while full -> no drop counted. 300 drops with CNT_W = 8 -> drop_count = 255.
- Async reset mid-stream: assert rst_n low between edges with level = 3 -> out_valid = 0 and level = 0 immediately. Post-reset push works normally.
